accumulate_seq: RTL and testbench

Parametrised accumulator sequencer: the next generation of the switch-driven accumulate/down-count block. A start pulse loads a sample count. The block then folds that many valid input samples into a result register using a selectable operation: add, subtract or running maximum. Overflow handling is either wrap or saturate. Completion is signalled with a busy/done handshake. It sits between a stimulus source (switches, or a producer with a valid strobe) and the LEDR/HEX display logic.

---
 rtl/accumulate_seq_if.sv | 33 +++
 rtl/accumulate_seq.sv | 130 +++++++++++++
 tb/tb_accumulate_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/accumulate_seq_if.sv
// Bus bundle for accumulate_seq: run control, sample stream and result/status.
// data_valid qualifies data_in; in RUN a sample is taken on every rising edge
// where data_valid=1. There is no ready: the block always accepts while busy.
interface accumulate_seq_if #(
    parameter int DATA_W = 5,
    parameter int CNT_W  = 5,
    parameter int SUM_W  = 10
);
    logic              start;
    logic              keep;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  count_in;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [1:0]        state_dbg;

    // Producer/controller side
    modport master (
        output start, keep, mode, count_in, data_in, data_valid,
        input  sum, count, busy, done, overflow, state_dbg
    );

    // Accumulator side
    modport slave (
        input  start, keep, mode, count_in, data_in, data_valid,
        output sum, count, busy, done, overflow, state_dbg
    );
endinterface

// File: rtl/accumulate_seq.sv
// Accumulator sequencer: a start pulse loads a sample count, then that many
// valid samples are folded into the result using add, subtract, max or hold,
// with wrap or saturate behaviour on overflow. busy marks the run and done
// pulses for one cycle at the end. state_dbg exposes the FSM state.
module accumulate_seq #(
    parameter int DATA_W   = 5,
    parameter int CNT_W    = 5,
    parameter int SUM_W    = 10,
    parameter int SATURATE = 0
) (
    input  logic CLOCK,
    input  logic RESET,
    accumulate_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;

    state_t           state;
    logic [1:0]       mode_q;
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;

    // One extra bit of headroom so the carry/borrow is visible.
    logic [SUM_W:0]   data_ext;
    logic [SUM_W:0]   add_full;
    logic [SUM_W:0]   sub_full;
    logic [SUM_W-1:0] sum_next;
    logic             ovf_next;

    // Result of folding the current sample into the sum under the latched mode
    always_comb begin
        data_ext = {{(SUM_W + 1 - DATA_W){1'b0}}, bus.data_in};
        add_full = {1'b0, sum_q} + data_ext;
        sub_full = {1'b0, sum_q} - data_ext;
        sum_next = sum_q;
        ovf_next = 1'b0;
        case (mode_q)
            MODE_ADD: begin
                ovf_next = add_full[SUM_W];
                if (ovf_next && (SATURATE != 0)) sum_next = '1;
                else                             sum_next = add_full[SUM_W-1:0];
            end
            MODE_SUB: begin
                ovf_next = (data_ext > {1'b0, sum_q});
                if (ovf_next && (SATURATE != 0)) sum_next = '0;
                else                             sum_next = sub_full[SUM_W-1:0];
            end
            MODE_MAX: begin
                if (data_ext > {1'b0, sum_q}) sum_next = data_ext[SUM_W-1:0];
            end
            default: begin
                sum_next = sum_q;
            end
        endcase
    end

    // Control FSM with all datapath registers and registered status outputs
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            mode_q     <= MODE_ADD;
            sum_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        count_q    <= bus.count_in;
                        mode_q     <= bus.mode;
                        overflow_q <= 1'b0;
                        if (!bus.keep) sum_q <= '0;
                        if (bus.count_in != '0) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end else begin
                            // Empty run goes straight to the completion pulse.
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.data_valid) begin
                        count_q <= count_q - CNT_W'(1);
                        sum_q   <= sum_next;
                        if (ovf_next) overflow_q <= 1'b1;
                        if (count_q == CNT_W'(1)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sum       = sum_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_accumulate_seq.sv
// Bench for accumulate_seq: three instances (default, 8-bit wrap, 8-bit
// saturate) share one directed stimulus stream. Expected {overflow,sum} is
// queued per instance when a run is launched and checked when done pulses.
module tb_accumulate_seq;

    logic       CLOCK;
    logic       RESET;
    logic       start;
    logic       keep;
    logic [1:0] mode;
    logic [4:0] count_in;
    logic [4:0] data_in;
    logic       data_valid;

    int tests_run = 0;
    int fails     = 0;
    int busy_cycles = 0;
    int done_cnt    = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];

    accumulate_seq_if #(.DATA_W(5), .CNT_W(5), .SUM_W(10)) b0 ();
    accumulate_seq_if #(.DATA_W(5), .CNT_W(5), .SUM_W(8))  b1 ();
    accumulate_seq_if #(.DATA_W(5), .CNT_W(5), .SUM_W(8))  b2 ();

    assign b0.start = start;  assign b1.start = start;  assign b2.start = start;
    assign b0.keep  = keep;   assign b1.keep  = keep;   assign b2.keep  = keep;
    assign b0.mode  = mode;   assign b1.mode  = mode;   assign b2.mode  = mode;
    assign b0.count_in = count_in; assign b1.count_in = count_in; assign b2.count_in = count_in;
    assign b0.data_in  = data_in;  assign b1.data_in  = data_in;  assign b2.data_in  = data_in;
    assign b0.data_valid = data_valid; assign b1.data_valid = data_valid; assign b2.data_valid = data_valid;

    accumulate_seq #(.DATA_W(5), .CNT_W(5), .SUM_W(10), .SATURATE(0)) dut0 (
        .CLOCK(CLOCK), .RESET(RESET), .bus(b0.slave));
    accumulate_seq #(.DATA_W(5), .CNT_W(5), .SUM_W(8), .SATURATE(0)) dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .bus(b1.slave));
    accumulate_seq #(.DATA_W(5), .CNT_W(5), .SUM_W(8), .SATURATE(1)) dut2 (
        .CLOCK(CLOCK), .RESET(RESET), .bus(b2.slave));

    // Clock
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests_run++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic start_run(input logic k, input logic [1:0] m, input logic [4:0] c);
        start = 1'b1; keep = k; mode = m; count_in = c; data_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [4:0] d, input logic v);
        data_in = d; data_valid = v;
        tick();
    endtask

    task automatic expect3(input int s0, input logic o0, input int s1, input logic o1,
                           input int s2, input logic o2);
        exp_q0.push_back({o0, 15'(s0)});
        exp_q1.push_back({o1, 15'(s1)});
        exp_q2.push_back({o2, 15'(s2)});
    endtask

    // Scoreboard: on each done pulse pop the expected result of that instance
    always @(posedge CLOCK) begin
        #1;
        if (b0.busy === 1'b1) busy_cycles++;
        if (b0.done === 1'b1) begin
            done_cnt++;
            check("done0_pending", (exp_q0.size() > 0), 1);
            if (exp_q0.size() > 0) check("result0", {b0.overflow, 15'(b0.sum)}, exp_q0.pop_front());
        end
        if (b1.done === 1'b1) begin
            check("done1_pending", (exp_q1.size() > 0), 1);
            if (exp_q1.size() > 0) check("result1", {b1.overflow, 15'(b1.sum)}, exp_q1.pop_front());
        end
        if (b2.done === 1'b1) begin
            check("done2_pending", (exp_q2.size() > 0), 1);
            if (exp_q2.size() > 0) check("result2", {b2.overflow, 15'(b2.sum)}, exp_q2.pop_front());
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Directed stimulus
    initial begin
        RESET = 1'b1; start = 1'b0; keep = 1'b0; mode = 2'b00;
        count_in = '0; data_in = '0; data_valid = 1'b0;

        // Reset and idle
        tick(); tick();
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("idle0", {b0.sum, b0.count, b0.busy, b0.done, b0.overflow}, 0);
            tick();
        end
        check("idle1", {b1.sum, b1.count, b1.busy, b1.done, b1.overflow}, 0);
        check("idle2", {b2.sum, b2.count, b2.busy, b2.done, b2.overflow}, 0);

        // Basic add: 3 x 5
        busy_cycles = 0; done_cnt = 0;
        expect3(15, 0, 15, 0, 15, 0);
        start_run(1'b0, 2'b00, 5'd3);
        check("add_busy_after_start", b0.busy, 1);
        feed(5'd5, 1'b1); feed(5'd5, 1'b1);
        check("add_not_done_early", b0.done, 0);
        feed(5'd5, 1'b1);
        check("add_done", b0.done, 1);
        check("add_busy_low_in_done", b0.busy, 0);
        data_valid = 1'b0;
        tick();
        check("add_done_one_cycle", b0.done, 0);
        check("add_busy_cycles", busy_cycles, 3);
        check("add_done_count", done_cnt, 1);

        // Valid gaps: 4 x 7 with pattern 1,0,1,1,0,1
        busy_cycles = 0;
        expect3(28, 0, 28, 0, 28, 0);
        start_run(1'b0, 2'b00, 5'd4);
        feed(5'd7, 1'b1); feed(5'd7, 1'b0); feed(5'd7, 1'b1);
        check("gap_count_mid", b0.count, 2);
        feed(5'd7, 1'b1); feed(5'd7, 1'b0); feed(5'd7, 1'b1);
        data_valid = 1'b0;
        tick();
        check("gap_busy_cycles", busy_cycles, 6);

        // Subtract with keep: 28 - 9 - 9
        expect3(10, 0, 10, 0, 10, 0);
        start_run(1'b1, 2'b01, 5'd2);
        check("sub_kept_sum", b0.sum, 28);
        feed(5'd9, 1'b1); feed(5'd9, 1'b1);
        data_valid = 1'b0;
        tick();

        // Overflow: 31 x 31 add
        expect3(961, 0, 193, 1, 255, 1);
        start_run(1'b0, 2'b00, 5'd31);
        for (int i = 0; i < 31; i++) feed(5'd31, 1'b1);
        data_valid = 1'b0;
        check("ovf_hold_idle1", b1.overflow, 1);
        tick();
        check("ovf_sum_after_done2", b2.sum, 255);

        // Underflow: 0 - 1
        expect3(1023, 1, 255, 1, 0, 1);
        start_run(1'b0, 2'b01, 5'd1);
        check("udf_cleared_on_start", b1.overflow, 0);
        feed(5'd1, 1'b1);
        data_valid = 1'b0;
        tick();

        // Max: 3, 17, 9
        expect3(17, 0, 17, 0, 17, 0);
        start_run(1'b0, 2'b10, 5'd3);
        feed(5'd3, 1'b1); feed(5'd17, 1'b1); feed(5'd9, 1'b1);
        data_valid = 1'b0;
        tick();

        // Zero count with keep
        busy_cycles = 0; done_cnt = 0;
        expect3(17, 0, 17, 0, 17, 0);
        start_run(1'b1, 2'b00, 5'd0);
        check("zero_done_next_cycle", b0.done, 1);
        check("zero_busy_low", b0.busy, 0);
        tick();
        check("zero_done_cleared", b0.done, 0);
        check("zero_busy_never", busy_cycles, 0);
        check("zero_sum_kept", b0.sum, 17);

        // Start ignored while busy, then reset mid-run
        done_cnt = 0;
        start_run(1'b0, 2'b00, 5'd10);
        feed(5'd1, 1'b1); feed(5'd1, 1'b1);
        start = 1'b1; keep = 1'b0; count_in = 5'd2;
        feed(5'd1, 1'b1);
        start = 1'b0;
        feed(5'd1, 1'b1);
        check("busy_start_ignored_sum", b0.sum, 4);
        check("busy_start_ignored_count", b0.count, 6);
        check("busy_still_high", b0.busy, 1);
        RESET = 1'b1;
        feed(5'd1, 1'b1);
        RESET = 1'b0;
        data_valid = 1'b0;
        check("rst_mid_sum", b0.sum, 0);
        check("rst_mid_count", b0.count, 0);
        check("rst_mid_busy", b0.busy, 0);
        check("rst_mid_state", b0.state_dbg, 0);
        for (int i = 0; i < 12; i++) tick();
        check("rst_mid_no_done", done_cnt, 0);

        // Every queued result must have been consumed
        check("queue0_empty", exp_q0.size(), 0);
        check("queue1_empty", exp_q1.size(), 0);
        check("queue2_empty", exp_q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
